// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: carries ID control words through EX/MEM/WB, resolves
// operand forwarding, stalls on load-use, kills the fetched instruction on
// redirects and counts stall/kill cycles with saturating counters.
//
// load-use counter lc:
//   lc     | meaning
//   0      | no stall owed beyond what a fresh load-use detect produces
//   1..3   | extra stall cycles still owed to a load-use already seen
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 3,
  parameter int NUM_SRC     = 2,
  parameter int CTRL_W      = 16,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_HW = 1,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [CTRL_W-1:0]             id_ctrl,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst,
  input  logic                          id_regwr,
  input  logic                          id_memrd,
  input  logic                          id_redirect,
  input  logic                          ex_redirect,
  output logic                          stall,
  output logic                          kill_if,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic [CTRL_W-1:0]             ex_ctrl,
  output logic [CTRL_W-1:0]             mem_ctrl,
  output logic [CTRL_W-1:0]             wb_ctrl,
  output logic [REG_ADDR_W-1:0]         ex_dst,
  output logic [REG_ADDR_W-1:0]         mem_dst,
  output logic [REG_ADDR_W-1:0]         wb_dst,
  output logic                          wb_regwr,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              kill_cnt
);

  // First stall cycle comes from the live detect; lc covers the rest.
  localparam logic [1:0] LC_RELOAD = 2'(LOAD_LAT - 1);

  logic                  ex_valid_q, ex_valid_d;
  logic                  ex_regwr_q, ex_regwr_d;
  logic                  ex_memrd_q, ex_memrd_d;
  logic [CTRL_W-1:0]     ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_regwr_q, mem_regwr_d;
  logic [CTRL_W-1:0]     mem_ctrl_q, mem_ctrl_d;
  logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_regwr_q, wb_regwr_d;
  logic [CTRL_W-1:0]     wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic [1:0]            lc_q, lc_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      kill_cnt_q, kill_cnt_d;

  logic [NUM_SRC-1:0]    hit_ex, hit_mem, hit_wb;
  logic                  load_use;
  logic                  bubble;

  function automatic logic src_hit(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  used,
    input logic                  stg_valid,
    input logic                  stg_regwr,
    input logic [REG_ADDR_W-1:0] stg_dst
  );
    logic zero_blk;
    zero_blk = (ZERO_REG_HW != 0) && (src == '0);
    return used && stg_valid && stg_regwr && (src == stg_dst) && !zero_blk;
  endfunction

  // Per-source producer match against each later stage, youngest wins.
  always_comb begin
    hit_ex  = '0;
    hit_mem = '0;
    hit_wb  = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_ex[i]  = src_hit(id_src[i*REG_ADDR_W +: REG_ADDR_W], id_src_used[i],
                           ex_valid_q, ex_regwr_q, ex_dst_q);
      hit_mem[i] = src_hit(id_src[i*REG_ADDR_W +: REG_ADDR_W], id_src_used[i],
                           mem_valid_q, mem_regwr_q, mem_dst_q);
      hit_wb[i]  = src_hit(id_src[i*REG_ADDR_W +: REG_ADDR_W], id_src_used[i],
                           wb_valid_q, wb_regwr_q, wb_dst_q);
      if (hit_ex[i]) begin
        fwd_sel[2*i +: 2] = 2'b01;
      end else if (hit_mem[i]) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end else if (hit_wb[i]) begin
        fwd_sel[2*i +: 2] = 2'b11;
      end
    end
  end

  // Stall/kill decisions; a redirect from EX overrides any load-use stall.
  always_comb begin
    load_use = ex_memrd_q & (|hit_ex);
    stall    = ~reset & ~ex_redirect & (load_use | (lc_q != 2'd0));
    kill_if  = ~reset & (ex_redirect | (id_redirect & ~stall));
    bubble   = ~id_valid | stall | ex_redirect;
  end

  // Next-state for the stage registers, load counter and perf counters.
  always_comb begin
    ex_valid_d  = ~bubble;
    ex_regwr_d  = ~bubble & id_regwr;
    ex_memrd_d  = ~bubble & id_memrd;
    ex_ctrl_d   = bubble ? '0 : id_ctrl;
    ex_dst_d    = bubble ? '0 : id_dst;
    mem_valid_d = ex_valid_q;
    mem_regwr_d = ex_regwr_q;
    mem_ctrl_d  = ex_ctrl_q;
    mem_dst_d   = ex_dst_q;
    wb_valid_d  = mem_valid_q;
    wb_regwr_d  = mem_regwr_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_dst_d    = mem_dst_q;

    lc_d = lc_q;
    if (ex_redirect) begin
      lc_d = 2'd0;
    end else if (load_use && (lc_q == 2'd0)) begin
      lc_d = LC_RELOAD;
    end else if (lc_q != 2'd0) begin
      lc_d = lc_q - 2'd1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    kill_cnt_d = kill_cnt_q;
    if (kill_if && (kill_cnt_q != '1)) begin
      kill_cnt_d = kill_cnt_q + CNT_W'(1);
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_regwr_q  <= 1'b0;
      ex_memrd_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_dst_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_regwr_q <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_dst_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_regwr_q  <= 1'b0;
      wb_ctrl_q   <= '0;
      wb_dst_q    <= '0;
      lc_q        <= 2'd0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_regwr_q  <= ex_regwr_d;
      ex_memrd_q  <= ex_memrd_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_dst_q    <= ex_dst_d;
      mem_valid_q <= mem_valid_d;
      mem_regwr_q <= mem_regwr_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_dst_q   <= mem_dst_d;
      wb_valid_q  <= wb_valid_d;
      wb_regwr_q  <= wb_regwr_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_dst_q    <= wb_dst_d;
      lc_q        <= lc_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign ex_dst    = ex_dst_q;
  assign mem_dst   = mem_dst_q;
  assign wb_dst    = wb_dst_q;
  assign wb_regwr  = wb_valid_q & wb_regwr_q;
  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=4) share one ID-stage stimulus; directed vectors, hand sequences
// and a randomized run against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        id_valid;
  logic [15:0] id_ctrl;
  logic [5:0]  id_src;
  logic [1:0]  id_src_used;
  logic [2:0]  id_dst;
  logic        id_regwr, id_memrd, id_redirect, ex_redirect;

  logic        o_stall [3];
  logic        o_kill  [3];
  logic [3:0]  o_fwd   [3];
  logic [15:0] o_exc   [3];
  logic [15:0] o_memc  [3];
  logic [15:0] o_wbc   [3];
  logic [2:0]  o_exd   [3];
  logic [2:0]  o_memd  [3];
  logic [2:0]  o_wbd   [3];
  logic        o_wbr   [3];
  logic [15:0] o_sc    [2];
  logic [15:0] o_kc    [2];
  logic [3:0]  sc4, kc4;

  pipe_hazard_ctrl u_lat1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_src(id_src), .id_src_used(id_src_used), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .id_redirect(id_redirect),
    .ex_redirect(ex_redirect), .stall(o_stall[0]), .kill_if(o_kill[0]),
    .fwd_sel(o_fwd[0]), .ex_ctrl(o_exc[0]), .mem_ctrl(o_memc[0]),
    .wb_ctrl(o_wbc[0]), .ex_dst(o_exd[0]), .mem_dst(o_memd[0]),
    .wb_dst(o_wbd[0]), .wb_regwr(o_wbr[0]), .stall_cnt(o_sc[0]),
    .kill_cnt(o_kc[0])
  );

  pipe_hazard_ctrl #(.LOAD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_src(id_src), .id_src_used(id_src_used), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .id_redirect(id_redirect),
    .ex_redirect(ex_redirect), .stall(o_stall[1]), .kill_if(o_kill[1]),
    .fwd_sel(o_fwd[1]), .ex_ctrl(o_exc[1]), .mem_ctrl(o_memc[1]),
    .wb_ctrl(o_wbc[1]), .ex_dst(o_exd[1]), .mem_dst(o_memd[1]),
    .wb_dst(o_wbd[1]), .wb_regwr(o_wbr[1]), .stall_cnt(o_sc[1]),
    .kill_cnt(o_kc[1])
  );

  pipe_hazard_ctrl #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_src(id_src), .id_src_used(id_src_used), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .id_redirect(id_redirect),
    .ex_redirect(ex_redirect), .stall(o_stall[2]), .kill_if(o_kill[2]),
    .fwd_sel(o_fwd[2]), .ex_ctrl(o_exc[2]), .mem_ctrl(o_memc[2]),
    .wb_ctrl(o_wbc[2]), .ex_dst(o_exd[2]), .mem_dst(o_memd[2]),
    .wb_dst(o_wbd[2]), .wb_regwr(o_wbr[2]), .stall_cnt(sc4),
    .kill_cnt(kc4)
  );

  function automatic logic [15:0] sc_of(input int k);
    return (k == 2) ? {12'd0, sc4} : o_sc[k];
  endfunction

  function automatic logic [15:0] kc_of(input int k);
    return (k == 2) ? {12'd0, kc4} : o_kc[k];
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [2:0] s0,
                       input logic [2:0] s1, input logic [1:0] u, input logic [2:0] d,
                       input logic wr, input logic rd, input logic idr, input logic exr);
    id_valid = v; id_ctrl = c; id_src = {s1, s0}; id_src_used = u; id_dst = d;
    id_regwr = wr; id_memrd = rd; id_redirect = idr; ex_redirect = exr;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: an in-flight instruction list [EX, MEM, WB] per instance.
  typedef struct {
    bit        v;
    bit [15:0] ctrl;
    bit [2:0]  dst;
    bit        wr;
    bit        rd;
  } stg_t;

  stg_t m_pipe [3][3];
  int   m_owed [3];
  int   m_scnt [3];
  int   m_kcnt [3];
  int   m_lat  [3] = '{1, 3, 1};
  int   m_cmax [3] = '{65535, 65535, 15};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) m_pipe[k][s] = '{0, 0, 0, 0, 0};
      m_owed[k] = 0; m_scnt[k] = 0; m_kcnt[k] = 0;
    end
  endtask

  task automatic model_eval(input int k, output logic st, output logic kl,
                            output logic [3:0] fw, output logic det);
    logic [2:0] src;
    fw = 4'd0;
    det = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src = id_src[i*3 +: 3];
      if (id_src_used[i] && src != 3'd0) begin
        for (int s = 0; s < 3; s++) begin
          if (m_pipe[k][s].v && m_pipe[k][s].wr && m_pipe[k][s].dst == src) begin
            fw[2*i +: 2] = 2'(s + 1);
            if (s == 0 && m_pipe[k][0].rd) det = 1'b1;
            break;
          end
        end
      end
    end
    st = !ex_redirect && (m_owed[k] > 0 || det);
    kl = ex_redirect || (id_redirect && !st);
  endtask

  task automatic model_step(input int k);
    logic st, kl, det;
    logic [3:0] fw;
    model_eval(k, st, kl, fw, det);
    m_pipe[k][2] = m_pipe[k][1];
    m_pipe[k][1] = m_pipe[k][0];
    if (id_valid && !st && !ex_redirect)
      m_pipe[k][0] = '{1, id_ctrl, id_dst, id_regwr, id_memrd};
    else
      m_pipe[k][0] = '{0, 0, 0, 0, 0};
    if (ex_redirect) m_owed[k] = 0;
    else if (m_owed[k] > 0) m_owed[k]--;
    else if (det) m_owed[k] = m_lat[k] - 1;
    if (st && m_scnt[k] < m_cmax[k]) m_scnt[k]++;
    if (kl && m_kcnt[k] < m_cmax[k]) m_kcnt[k]++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        v;
    logic [15:0] ctrl;
    logic [2:0]  s0, s1;
    logic [1:0]  used;
    logic [2:0]  dst;
    logic        wr, rd, idr, exr;
    logic        e_stall, e_kill;
    logic [3:0]  e_fwd;
    logic [15:0] e_ex;
    logic        e_wbr;
  } vec_t;

  vec_t vec [13];

  initial begin
    reset = 1'b1;
    idle();
    model_reset();

    vec[0]  = '{1, 16'h00A1, 3'd0, 3'd0, 2'b00, 3'd0, 1, 0, 0, 0,  0, 0, 4'b0000, 16'h0000, 0};
    vec[1]  = '{1, 16'h00A2, 3'd0, 3'd0, 2'b00, 3'd1, 1, 0, 0, 0,  0, 0, 4'b0000, 16'h00A1, 0};
    vec[2]  = '{1, 16'h00A3, 3'd0, 3'd0, 2'b00, 3'd1, 1, 0, 0, 0,  0, 0, 4'b0000, 16'h00A2, 0};
    vec[3]  = '{1, 16'h00A4, 3'd1, 3'd0, 2'b10, 3'd1, 1, 0, 0, 0,  0, 0, 4'b0000, 16'h00A3, 1};
    vec[4]  = '{0, 16'h0000, 3'd1, 3'd0, 2'b11, 3'd0, 0, 0, 0, 0,  0, 0, 4'b0001, 16'h00A4, 1};
    vec[5]  = '{0, 16'h0000, 3'd1, 3'd0, 2'b11, 3'd0, 0, 0, 0, 0,  0, 0, 4'b0010, 16'h0000, 1};
    vec[6]  = '{0, 16'h0000, 3'd1, 3'd0, 2'b11, 3'd0, 0, 0, 0, 0,  0, 0, 4'b0011, 16'h0000, 1};
    vec[7]  = '{0, 16'h0000, 3'd1, 3'd0, 2'b11, 3'd0, 0, 0, 0, 0,  0, 0, 4'b0000, 16'h0000, 0};
    vec[8]  = '{1, 16'h00B1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1, 0, 0,  0, 0, 4'b0000, 16'h0000, 0};
    vec[9]  = '{1, 16'h00B2, 3'd2, 3'd0, 2'b01, 3'd3, 1, 0, 0, 0,  1, 0, 4'b0001, 16'h00B1, 0};
    vec[10] = '{1, 16'h00B2, 3'd2, 3'd0, 2'b01, 3'd3, 1, 0, 0, 0,  0, 0, 4'b0010, 16'h0000, 0};
    vec[11] = '{0, 16'h0000, 3'd0, 3'd2, 2'b10, 3'd0, 0, 0, 0, 0,  0, 0, 4'b1100, 16'h00B2, 1};
    vec[12] = '{0, 16'h0000, 3'd0, 3'd0, 2'b00, 3'd0, 0, 0, 1, 0,  0, 1, 4'b0000, 16'h0000, 0};

    // Reset values while reset is held
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d stall", k), o_stall[k], 0);
      chk($sformatf("rst%0d kill", k), o_kill[k], 0);
      chk($sformatf("rst%0d fwd", k), o_fwd[k], 0);
      chk($sformatf("rst%0d ctrl", k), {o_exc[k], o_memc[k] | o_wbc[k]}, 0);
      chk($sformatf("rst%0d wbr", k), o_wbr[k], 0);
      chk($sformatf("rst%0d cnts", k), {sc_of(k), kc_of(k)}, 0);
    end
    tick();
    reset = 1'b0;

    // Directed vectors on the LOAD_LAT=1 instance
    for (int r = 0; r < 13; r++) begin
      drive(vec[r].v, vec[r].ctrl, vec[r].s0, vec[r].s1, vec[r].used, vec[r].dst,
            vec[r].wr, vec[r].rd, vec[r].idr, vec[r].exr);
      @(negedge clk);
      chk($sformatf("vec%0d stall", r), o_stall[0], vec[r].e_stall);
      chk($sformatf("vec%0d kill", r), o_kill[0], vec[r].e_kill);
      chk($sformatf("vec%0d fwd", r), o_fwd[0], vec[r].e_fwd);
      chk($sformatf("vec%0d ex_ctrl", r), o_exc[0], vec[r].e_ex);
      chk($sformatf("vec%0d wb_regwr", r), o_wbr[0], vec[r].e_wbr);
      tick();
    end
    idle();
    @(negedge clk);
    chk("vec stall_cnt", o_sc[0], 1);
    chk("vec kill_cnt", o_kc[0], 1);

    // LOAD_LAT=3 load-use: three stall cycles, three bubbles
    do_reset();
    drive(1, 16'h00C1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1, 0, 0);
    tick();
    drive(1, 16'h00C2, 3'd2, 3'd0, 2'b01, 3'd3, 1, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("lat3 t%0d stall", t), o_stall[1], t < 3);
      chk($sformatf("lat3 t%0d ex_ctrl", t), o_exc[1], (t == 0) ? 16'h00C1 : 16'h0000);
      chk($sformatf("lat3 t%0d fwd", t), o_fwd[1], (t == 3) ? 0 : t + 1);
      tick();
    end
    @(negedge clk);
    chk("lat3 ex_ctrl after stall", o_exc[1], 16'h00C2);
    chk("lat3 stall_cnt", o_sc[1], 3);

    // Async reset in the middle of a LOAD_LAT=3 stall
    do_reset();
    drive(1, 16'h00C1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1, 0, 0);
    tick();
    drive(1, 16'h00C2, 3'd2, 3'd0, 2'b01, 3'd3, 1, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("midrst pre stall", o_stall[1], 1);
    reset = 1'b1;
    #1;
    chk("midrst stall", o_stall[1], 0);
    chk("midrst kill", o_kill[1], 0);
    chk("midrst fwd", o_fwd[1], 0);
    chk("midrst ctrl", {o_exc[1], o_memc[1] | o_wbc[1]}, 0);
    chk("midrst wbr", o_wbr[1], 0);
    chk("midrst stall_cnt", o_sc[1], 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("postrst stall", o_stall[1], 0);
    chk("postrst ex_ctrl", o_exc[1], 0);
    tick();
    @(negedge clk);
    chk("postrst stall2", o_stall[1], 0);
    chk("postrst ex_ctrl2", o_exc[1], 16'h00C2);

    // ex_redirect coinciding with a load-use detect
    do_reset();
    drive(1, 16'h00C1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1, 0, 0);
    tick();
    drive(1, 16'h00C2, 3'd2, 3'd0, 2'b01, 3'd3, 1, 0, 0, 1);
    @(negedge clk);
    chk("exr stall", o_stall[0], 0);
    chk("exr kill", o_kill[0], 1);
    chk("exr lat3 stall", o_stall[1], 0);
    chk("exr lat3 kill", o_kill[1], 1);
    tick();
    idle();
    @(negedge clk);
    chk("exr ex_ctrl", o_exc[0], 0);
    chk("exr kill_cnt", o_kc[0], 1);
    chk("exr stall_cnt", o_sc[0], 0);
    chk("exr lat3 no stall", o_stall[1], 0);
    chk("exr lat3 stall_cnt", o_sc[1], 0);

    // id_redirect held back while ID is stalled
    do_reset();
    drive(1, 16'h00C1, 3'd0, 3'd0, 2'b00, 3'd2, 1, 1, 0, 0);
    tick();
    drive(1, 16'h00C3, 3'd2, 3'd0, 2'b01, 3'd0, 0, 0, 1, 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("idr t%0d stall", t), o_stall[0], t == 0);
      chk($sformatf("idr t%0d kill", t), o_kill[0], t != 0);
      chk($sformatf("idr lat3 t%0d stall", t), o_stall[1], t < 3);
      chk($sformatf("idr lat3 t%0d kill", t), o_kill[1], t == 3);
      tick();
    end

    // Counter saturation: 20 stall cycles, then 20 kill cycles
    do_reset();
    drive(1, 16'h00D1, 3'd2, 3'd0, 2'b01, 3'd2, 1, 1, 0, 0);
    repeat (40) tick();
    idle();
    @(negedge clk);
    chk("sat stall_cnt16", o_sc[0], 20);
    chk("sat stall_cnt4", sc4, 15);
    ex_redirect = 1'b1;
    repeat (20) tick();
    idle();
    @(negedge clk);
    chk("sat kill_cnt16", o_kc[0], 20);
    chk("sat kill_cnt4", kc4, 15);
    chk("sat stall_cnt4 hold", sc4, 15);

    // Randomized run against the model, all three instances
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom_range(1, 65535)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic st, kl, det;
        logic [3:0] fw;
        model_eval(k, st, kl, fw, det);
        chk($sformatf("rnd%0d.%0d stall", n, k), o_stall[k], st);
        chk($sformatf("rnd%0d.%0d kill", n, k), o_kill[k], kl);
        chk($sformatf("rnd%0d.%0d fwd", n, k), o_fwd[k], fw);
        chk($sformatf("rnd%0d.%0d ctrl", n, k), {o_exc[k], o_memc[k]},
            {m_pipe[k][0].ctrl, m_pipe[k][1].ctrl});
        chk($sformatf("rnd%0d.%0d wb_ctrl", n, k), o_wbc[k], m_pipe[k][2].ctrl);
        chk($sformatf("rnd%0d.%0d wb_regwr", n, k), o_wbr[k],
            m_pipe[k][2].v && m_pipe[k][2].wr);
        if (m_pipe[k][0].v) chk($sformatf("rnd%0d.%0d ex_dst", n, k), o_exd[k], m_pipe[k][0].dst);
        if (m_pipe[k][1].v) chk($sformatf("rnd%0d.%0d mem_dst", n, k), o_memd[k], m_pipe[k][1].dst);
        if (m_pipe[k][2].v) chk($sformatf("rnd%0d.%0d wb_dst", n, k), o_wbd[k], m_pipe[k][2].dst);
        chk($sformatf("rnd%0d.%0d cnts", n, k), {sc_of(k), kc_of(k)},
            {16'(m_scnt[k]), 16'(m_kcnt[k])});
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and control-pipeline unit for the 4-stage-after-fetch processor pipeline (IF, ID, EX, MEM, WB). It takes the decoded control word and register usage from ID. It carries control words through EX/MEM/WB, inserting bubbles where needed, and produces forwarding selects, load-use stalls and wrong-path kills. It also keeps saturating stall/kill performance counters.

Parameters:
REG_ADDR_W, 3, register-address width
NUM_SRC, 2, source operands per instruction (1..4)
CTRL_W, 16, width of decoded control word carried down the pipe
LOAD_LAT, 1, bubbles per load-use hazard (1..4)
ZERO_REG_HW, 1, 1 = register 0 hardwired: never matched for forwarding or hazards
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_ctrl  in  CTRL_W  decoded control word of ID instruction
id_src  in  NUM_SRC*REG_ADDR_W  source register addresses; src i at [i*REG_ADDR_W +: REG_ADDR_W]
id_src_used  in  NUM_SRC  per-source read enable
id_dst  in  REG_ADDR_W  destination register
id_regwr  in  1  ID instruction writes a register
id_memrd  in  1  ID instruction is a load
id_redirect  in  1  jump resolved in ID
ex_redirect  in  1  taken branch resolved in EX
stall  out  1  hold PC and IF/ID
kill_if  out  1  flush IF/ID register
fwd_sel  out  2*NUM_SRC  per source: 00 regfile, 01 EX, 10 MEM, 11 WB
ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  stage control words (0 = bubble)
ex_dst, mem_dst, wb_dst  out  REG_ADDR_W each  stage destinations
wb_regwr  out  1  register write enable at WB (valid & regwr)
stall_cnt, kill_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset: all stage valid/regwr/memrd flags 0, ctrl and dst registers 0, load counter 0, stall=0, kill_if=0, fwd_sel=0, both perf counters 0. Async assertion clears immediately; release takes effect at the next edge.
- Stage registers advance every cycle, never held: WB<=MEM, MEM<=EX, EX<=ID or bubble.
- Bubble (valid=0, ctrl=0, regwr=0, memrd=0) enters EX when any of these holds: ~id_valid, stall, or ex_redirect.
- Forwarding (combinational): source i matches stage S if id_src_used[i], S.valid, S.regwr, src==S.dst, and not (ZERO_REG_HW and src==0).
  - Priority EX > MEM > WB.
  - No match gives 00.
- Load-use detect (combinational): any used source matches EX with EX.memrd=1.
- Load counter lc (2 bits):
  - On detect with lc==0 and no ex_redirect: lc <= LOAD_LAT-1.
  - Else if lc!=0: lc decrements.
- stall = (detect | lc!=0) & ~ex_redirect. Total consecutive stall cycles per hazard is exactly LOAD_LAT.
- ex_redirect clears lc to 0 the same edge. Kill has priority over stall.
- kill_if = ex_redirect | (id_redirect & ~stall). A jump sitting in a stalled ID is acted on only when it leaves ID.
- ex_redirect also bubbles the ID instruction. id_redirect lets the ID instruction proceed.
- stall_cnt increments each cycle stall=1. kill_cnt increments each cycle kill_if=1. Both saturate at all-ones with no wrap.
- Simultaneous detect and ex_redirect: no stall, kill_if=1, bubble into EX, lc=0.
- Reset mid-stall: lc and all stages cleared; no residual stall after release.

Test Plan:
- Reset: assert reset mid-run -> all outputs 0 immediately; first cycle after release stall=0, ex_ctrl=0.
- Forward priority:
  - Stimulus: ADD r1 (EX), SUB r1 (MEM), AND r1 (WB); ID reads r1 on src0.
  - Response: fwd_sel[1:0]=01. After EX and MEM hold bubbles: 11.
  - Also: src r0 with ZERO_REG_HW=1 -> 00.
- Load-use, LOAD_LAT=1:
  - Stimulus: load r2 in EX, ID reads r2.
  - Response: stall=1 for exactly 1 cycle and ex_ctrl=0 next cycle. Then fwd_sel=10, stall_cnt=1.
- Load-use, LOAD_LAT=3: same stimulus -> stall high 3 consecutive cycles, 3 bubbles, stall_cnt=3.
- Kill:
  - ex_redirect during detected load-use -> stall=0, kill_if=1, EX bubble next cycle, kill_cnt=1.
  - id_redirect with stall=1 -> kill_if=0 until stall drops.
- Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.
